store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 25 ++
 rtl/store_buffer.sv | 109 ++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Core/memory-side signal bundle for the store buffer.
// The master side is the core plus data memory; the slave side is the buffer.
interface store_buffer_if;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        Empty;
    logic        DMemWe;
    logic [31:0] DMemAdr;
    logic [31:0] DMemWd;
    logic [31:0] DMemRd;

    modport master (
        output MemWriteM, MemReadM, DataAdrM, WriteDataM, DMemRd,
        input  ReadDataM, StallM, Empty, DMemWe, DMemAdr, DMemWd
    );

    modport slave (
        input  MemWriteM, MemReadM, DataAdrM, WriteDataM, DMemRd,
        output ReadDataM, StallM, Empty, DMemWe, DMemAdr, DMemWd
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending word stores between the core
// memory stage and data memory, with youngest-match load forwarding.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic        full;
    logic        enq;
    logic        drain;
    logic        load;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Handshake decode; a load (even one ignored because a store is also
    // presented) always takes the memory port, so draining waits for MemReadM=0.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        enq   = bus.MemWriteM && !full;
        drain = (count_q != '0) && !bus.MemReadM;
        load  = bus.MemReadM && !bus.MemWriteM;
    end

    // Pointer, occupancy and valid-bit next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (drain) begin
            head_d          = head_q + PW'(1);
            valid_d[head_q] = 1'b0;
        end
        if (enq) begin
            tail_d          = tail_q + PW'(1);
            valid_d[tail_q] = 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; contents are qualified by valid_q so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= bus.DataAdrM[31:2];
            data_q[tail_q] <= bus.WriteDataM;
        end
    end

    // Forwarding search from oldest to youngest so the last hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == bus.DataAdrM[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    // Core and memory side outputs.
    always_comb begin
        bus.StallM    = bus.MemWriteM && full;
        bus.Empty     = (count_q == '0);
        bus.DMemWe    = drain;
        bus.DMemAdr   = bus.MemReadM ? bus.DataAdrM : {addr_q[head_q], 2'b00};
        bus.DMemWd    = data_q[head_q];
        bus.ReadDataM = '0;
        if (load) begin
            bus.ReadDataM = fwd_hit ? fwd_data : bus.DMemRd;
        end
    end

endmodule
